// File: rtl/proc_ctrl_if.sv
// rtl/proc_ctrl_if.sv - control/datapath signal bundle for the 5-stage pipeline controller
//
// Purpose : groups every datapath-to-control (d2c_*) and control-to-datapath
//           (c2d_*) signal of proc_ctrl so the controller and datapath connect
//           through one port.
// Modports: master - the controller: reads d2c_*, drives c2d_* and illegal_inst
//           slave  - the datapath:   drives d2c_*, reads c2d_* and illegal_inst
// Signals :
//   d2c_inst            instruction word held in the D-stage IR
//   d2c_eq_X            ALU compare bit from X (reserved, no supported op uses it)
//   c2d_imemreq_val_F   instruction memory request valid
//   c2d_reg_en_F        PC register enable
//   c2d_pc_sel_F        next-PC select (0 = pc+4)
//   c2d_reg_en_D        IR enable
//   c2d_imm_type_D      immediate format (0 I, 1 S)
//   c2d_op1_byp_sel_D   op1 bypass source (0 RF, 1 X, 2 M, 3 W)
//   c2d_op2_byp_sel_D   op2 bypass source (0 RF, 1 X, 2 M, 3 W)
//   c2d_op1_sel_D       op1 mux (0 bypass)
//   c2d_op2_sel_D       op2 mux (0 bypass, 1 immediate)
//   c2d_alu_fn_X        ALU function (0 add)
//   c2d_result_sel_X    X result (0 ALU, 1 multiplier)
//   c2d_dmemreq_val_M   data memory request valid
//   c2d_dmemreq_type_M  data memory request type (0 read, 1 write)
//   c2d_wb_sel_M        writeback source (0 result, 1 load data)
//   c2d_rf_wen_W        register file write enable
//   c2d_rf_waddr_W      register file write address
//   illegal_inst        sticky illegal-instruction flag

interface proc_ctrl_if;
   logic [31:0] d2c_inst;
   logic        d2c_eq_X;

   logic        c2d_imemreq_val_F;
   logic        c2d_reg_en_F;
   logic [1:0]  c2d_pc_sel_F;

   logic        c2d_reg_en_D;
   logic [1:0]  c2d_imm_type_D;
   logic [1:0]  c2d_op1_byp_sel_D;
   logic [1:0]  c2d_op2_byp_sel_D;
   logic        c2d_op1_sel_D;
   logic        c2d_op2_sel_D;

   logic        c2d_alu_fn_X;
   logic        c2d_result_sel_X;
   logic        c2d_dmemreq_val_M;
   logic        c2d_dmemreq_type_M;
   logic        c2d_wb_sel_M;
   logic        c2d_rf_wen_W;
   logic [4:0]  c2d_rf_waddr_W;

   logic        illegal_inst;

   modport master (
      input  d2c_inst, d2c_eq_X,
      output c2d_imemreq_val_F, c2d_reg_en_F, c2d_pc_sel_F,
             c2d_reg_en_D, c2d_imm_type_D, c2d_op1_byp_sel_D, c2d_op2_byp_sel_D,
             c2d_op1_sel_D, c2d_op2_sel_D,
             c2d_alu_fn_X, c2d_result_sel_X, c2d_dmemreq_val_M, c2d_dmemreq_type_M,
             c2d_wb_sel_M, c2d_rf_wen_W, c2d_rf_waddr_W,
             illegal_inst
   );

   modport slave (
      output d2c_inst, d2c_eq_X,
      input  c2d_imemreq_val_F, c2d_reg_en_F, c2d_pc_sel_F,
             c2d_reg_en_D, c2d_imm_type_D, c2d_op1_byp_sel_D, c2d_op2_byp_sel_D,
             c2d_op1_sel_D, c2d_op2_sel_D,
             c2d_alu_fn_X, c2d_result_sel_X, c2d_dmemreq_val_M, c2d_dmemreq_type_M,
             c2d_wb_sel_M, c2d_rf_wen_W, c2d_rf_waddr_W,
             illegal_inst
   );
endinterface

// File: rtl/proc_ctrl.sv
// rtl/proc_ctrl.sv - control unit for a 5-stage (F/D/X/M/W) in-order pipeline
//
// Purpose : decodes the instruction held in D (ADD, MUL, ADDI, LW, SW), steers
//           operand bypassing from X/M/W, inserts a one-cycle bubble on a
//           load-use hazard, carries per-instruction control down the pipe and
//           turns illegal instructions into bubbles while raising a sticky flag.
// Ports   :
//   clk  - sole clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - proc_ctrl_if.master: d2c_* inputs from the datapath, c2d_* controls
//          and illegal_inst outputs to the datapath

module proc_ctrl (
   input  logic        clk,
   input  logic        rst,
   proc_ctrl_if.master bus
);

   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [1:0] BYP_RF = 2'd0;
   localparam logic [1:0] BYP_X  = 2'd1;
   localparam logic [1:0] BYP_M  = 2'd2;
   localparam logic [1:0] BYP_W  = 2'd3;

   // Control carried with an instruction from X to W. An all-zero record is a bubble.
   typedef struct packed {
      logic       val;
      logic [4:0] rd;
      logic       rf_wen;
      logic       is_load;
      logic       dmem_val;
      logic       dmem_type;
      logic       wb_sel;
      logic       result_sel;
   } stage_t;

   // ---------------------------------------------------------------- state
   logic   val_d_q, val_d_d;
   stage_t x_q, x_d;
   stage_t m_q, m_d;
   stage_t w_q, w_d;
   logic   illegal_inst_q, illegal_inst_d;

   // ---------------------------------------------------------------- decode
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rs1, rs2, rd;

   logic       is_add, is_mul, is_addi, is_lw, is_sw, legal;
   logic       rs1_used, rs2_used;
   logic [1:0] dec_imm_type;
   logic       dec_op2_sel;
   logic       dec_rf_wen;
   logic       dec_result_sel;

   always_comb begin
      opcode = bus.d2c_inst[6:0];
      rd     = bus.d2c_inst[11:7];
      funct3 = bus.d2c_inst[14:12];
      rs1    = bus.d2c_inst[19:15];
      rs2    = bus.d2c_inst[24:20];
      funct7 = bus.d2c_inst[31:25];

      is_add  = (opcode == OP_REG)   && (funct3 == 3'b000) && (funct7 == 7'b0000000);
      is_mul  = (opcode == OP_REG)   && (funct3 == 3'b000) && (funct7 == 7'b0000001);
      is_addi = (opcode == OP_IMM)   && (funct3 == 3'b000);
      is_lw   = (opcode == OP_LOAD)  && (funct3 == 3'b010);
      is_sw   = (opcode == OP_STORE) && (funct3 == 3'b010);
      legal   = is_add | is_mul | is_addi | is_lw | is_sw;

      // An illegal word reads nothing, so it can never cause a load-use stall.
      rs1_used = val_d_q && legal;
      rs2_used = val_d_q && (is_add | is_mul | is_sw);

      dec_imm_type   = is_sw ? 2'd1 : 2'd0;
      dec_op2_sel    = is_addi | is_lw | is_sw;
      dec_result_sel = is_mul;
      // x0 is hardwired: a write to it is dropped at decode, so it never
      // shows up as a bypass source either.
      dec_rf_wen     = (is_add | is_mul | is_addi | is_lw) && (rd != 5'd0);
   end

   // ---------------------------------------------------------------- hazards
   logic load_use;
   logic stall;

   always_comb begin
      load_use = x_q.val && x_q.is_load && (x_q.rd != 5'd0) &&
                 ((rs1_used && (rs1 == x_q.rd)) || (rs2_used && (rs2 == x_q.rd)));
      stall    = load_use;
   end

   // Youngest producer wins. A load in X has no data yet, so it is never a
   // bypass source; the stall holds D until the load reaches M.
   function automatic logic [1:0] byp_sel(input logic used, input logic [4:0] rs,
                                          input stage_t sx, input stage_t sm,
                                          input stage_t sw);
      logic [1:0] sel;
      sel = BYP_RF;
      if (used && (rs != 5'd0)) begin
         if (sx.val && sx.rf_wen && !sx.is_load && (sx.rd == rs)) begin
            sel = BYP_X;
         end else if (sm.val && sm.rf_wen && (sm.rd == rs)) begin
            sel = BYP_M;
         end else if (sw.val && sw.rf_wen && (sw.rd == rs)) begin
            sel = BYP_W;
         end
      end
      return sel;
   endfunction

   logic [1:0] op1_byp_sel, op2_byp_sel;

   always_comb begin
      op1_byp_sel = byp_sel(rs1_used, rs1, x_q, m_q, w_q);
      op2_byp_sel = byp_sel(rs2_used, rs2, x_q, m_q, w_q);
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      // D is refilled every cycle the IR is enabled; during a stall it keeps
      // its instruction (and its valid bit).
      val_d_d = stall ? val_d_q : 1'b1;

      x_d = '0;
      if (val_d_q && legal && !stall) begin
         x_d.val        = 1'b1;
         x_d.rd         = rd;
         x_d.rf_wen     = dec_rf_wen;
         x_d.is_load    = is_lw;
         x_d.dmem_val   = is_lw | is_sw;
         x_d.dmem_type  = is_sw;
         x_d.wb_sel     = is_lw;
         x_d.result_sel = dec_result_sel;
      end

      m_d = x_q;
      w_d = m_q;

      // The flag rises on the edge the illegal word would have entered X.
      illegal_inst_d = illegal_inst_q | (val_d_q && !legal);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_d_q        <= 1'b0;
         x_q            <= '0;
         m_q            <= '0;
         w_q            <= '0;
         illegal_inst_q <= 1'b0;
      end else begin
         val_d_q        <= val_d_d;
         x_q            <= x_d;
         m_q            <= m_d;
         w_q            <= w_d;
         illegal_inst_q <= illegal_inst_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   logic dec_ok;
   assign dec_ok = val_d_q && legal;

   assign bus.c2d_imemreq_val_F  = !rst;
   assign bus.c2d_reg_en_F       = !stall;
   assign bus.c2d_pc_sel_F       = 2'd0;

   assign bus.c2d_reg_en_D       = !stall;
   assign bus.c2d_imm_type_D     = dec_ok ? dec_imm_type : 2'd0;
   assign bus.c2d_op1_byp_sel_D  = op1_byp_sel;
   assign bus.c2d_op2_byp_sel_D  = op2_byp_sel;
   assign bus.c2d_op1_sel_D      = 1'b0;
   assign bus.c2d_op2_sel_D      = dec_ok && dec_op2_sel;

   assign bus.c2d_alu_fn_X       = 1'b0;
   assign bus.c2d_result_sel_X   = x_q.val && x_q.result_sel;

   assign bus.c2d_dmemreq_val_M  = m_q.val && m_q.dmem_val;
   assign bus.c2d_dmemreq_type_M = m_q.val && m_q.dmem_type;
   assign bus.c2d_wb_sel_M       = m_q.val && m_q.wb_sel;

   assign bus.c2d_rf_wen_W       = w_q.val && w_q.rf_wen;
   assign bus.c2d_rf_waddr_W     = w_q.rd;

   assign bus.illegal_inst       = illegal_inst_q;

   // The compare bit is reserved for branch support.
   logic unused_eq;
   assign unused_eq = bus.d2c_eq_X;

endmodule

// File: doc/proc_ctrl.md
PROC_CTRL -- requirements
Module: proc_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: d2c_inst  in  32  instruction held in D; d2c_eq_X  in  1  ALU compare bit (unused by supported ISA, reserved).
REQ-003 SHALL drive fetch controls: c2d_imemreq_val_F  out  1; c2d_reg_en_F  out  1  PC enable; c2d_pc_sel_F  out  2  (0 = pc+4).
REQ-004 SHALL drive decode controls: c2d_reg_en_D  out  1  IR enable; c2d_imm_type_D  out  2  (0 I, 1 S); c2d_op1_byp_sel_D, c2d_op2_byp_sel_D  out  2 each  (0 RF, 1 X, 2 M, 3 W); c2d_op1_sel_D  out  1  (0 bypass); c2d_op2_sel_D  out  1  (0 bypass, 1 imm).
REQ-005 SHALL drive X/M/W controls: c2d_alu_fn_X  out  1  (0 add); c2d_result_sel_X  out  1  (0 ALU, 1 MUL); c2d_dmemreq_val_M  out  1; c2d_dmemreq_type_M  out  1  (0 read, 1 write); c2d_wb_sel_M  out  1  (0 result, 1 rdata); c2d_rf_wen_W  out  1; c2d_rf_waddr_W  out  5.
REQ-006 SHALL output illegal_inst  out  1  sticky flag, set on first illegal instruction reaching X.

Function
REQ-007 SHALL decode ADD (opcode 0110011, f3 000, f7 0000000), MUL (0110011, 000, 0000001), ADDI (0010011, 000), LW (0000011, 010), SW (0100011, 010); any other word in a valid D slot is illegal.
REQ-008 SHALL keep per-stage state val_X, val_M, val_W plus val_D, and carry rd, rf_wen, is_load, dmem val/type, wb_sel, result_sel down the pipeline one stage per cycle.
REQ-009 SHALL assert c2d_imemreq_val_F = 1 whenever rst = 0; c2d_pc_sel_F SHALL always be 0.
REQ-010 SHALL set val_D <= 1 on every cycle c2d_reg_en_D = 1 after reset; val_D holds during stall.
REQ-011 SHALL decode per class: ADD/MUL op2_sel 0, wen 1; ADDI imm_type 0, op2_sel 1, wen 1; LW imm_type 0, op2_sel 1, wen 1, load, wb_sel 1; SW imm_type 1, op2_sel 1, wen 0, dmem write; MUL result_sel 1, others 0; alu_fn always 0; op1_sel always 0.
REQ-012 SHALL treat rs1 as read by all five ops and rs2 as read by ADD, MUL, SW only.
REQ-013 SHALL set bypass select per operand to highest-priority match of X, then M, then W, where match = stage valid, stage rf_wen, stage rd == rs, rd != 0; else 0 (RF).
REQ-014 SHALL detect load-use: valid D reads rs equal to rd (!= 0) of valid load in X; then c2d_reg_en_F = 0, c2d_reg_en_D = 0, val_X <= 0 next cycle (bubble); no bypass from X for that operand.
REQ-015 SHALL hold stall exactly one cycle per load-use hazard; the load then in M is bypassed via select 2.
REQ-016 SHALL gate c2d_dmemreq_val_M and c2d_rf_wen_W with val_M / val_W; c2d_rf_waddr_W = rd of W.
REQ-017 SHALL convert illegal instruction into bubble (no RF/memory effect) and set illegal_inst on its X cycle; flag clears only on reset.
REQ-018 SHALL write x0 never: rf_wen forced 0 when rd == 0.
REQ-019 SHALL produce full throughput (one instruction retired per cycle) absent load-use hazards; latency fetch-to-W = 4 cycles.

Reset
REQ-020 SHALL, while rst = 1, clear val_D/X/M/W and illegal_inst asynchronously; drive c2d_imemreq_val_F 0, c2d_reg_en_F 1, c2d_reg_en_D 1, all other outputs 0.
REQ-021 SHALL discard in-flight instructions on reset asserted mid-stream; no RF or memory write after rst rises.
REQ-022 SHALL fetch first instruction in first cycle after rst falls; first W writeback no earlier than cycle 4.

Verification
REQ-023 Reset: hold rst 3 cycles mid-stream -> all val 0, rf_wen_W 0, dmemreq_val_M 0, imemreq_val 0; release -> imemreq_val 1 next edge.
REQ-024 Back-to-back: ADDI x1,x0,5; ADD x2,x1,x1 -> op1/op2_byp_sel_D = 1 for ADD; no stall; rf_waddr_W 1 then 2 consecutive cycles.
REQ-025 Load-use: LW x3,0(x1); ADD x4,x3,x0 -> one cycle reg_en_F = reg_en_D = 0, bubble in X, then op1_byp_sel_D = 2.
REQ-026 Priority/x0: ADDI x5 then ADDI x5 then ADD x6,x5,x0 -> op1 sel 1 (X beats M), op2 sel 0; ADDI x0,x0,1 -> rf_wen_W 0.
REQ-027 Store: SW x2,4(x1) -> imm_type_D 1, op2_sel 1, dmemreq_val_M 1, type 1, rf_wen_W 0 on W.
REQ-028 Illegal: word 0xFFFFFFFF in D -> illegal_inst 1 from its X cycle onward, no writes; next instruction executes normally.
